mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Pipeline MEM stage. Sits directly downstream of the execute stage and consumes its EX/MEM register outputs.
- Performs loads and stores over a req/ack data-memory port, with byte-lane steering, load extraction and sign/zero extension.
- Stalls the upstream stages while an access is outstanding and registers the MEM/WB outputs for writeback.
- Includes a timeout counter that guards against a memory that never acks.

Parameters:
- TIMEOUT_CYCLES, 255: max WAIT cycles before the access is aborted; 0 disables the timeout.
- TCNT_W, 8: width of the timeout counter; must satisfy 2^TCNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ALU_out_EXMEM  in  32  effective address / ALU result
- funct3_EXMEM  in  3  access size/sign
- mem_wr_en_EXMEM  in  1  store request
- rs2_data_EXMEM  in  32  store data
- reg_wr_en_EXMEM  in  1  writeback enable
- reg_wr_ctrl_EXMEM  in  2  writeback select: 00 ALU, 01 load data, 10 pc+4
- rd_EXMEM  in  5  destination register
- pc_4_EXMEM  in  32  pc+4
- dmem_req  out  1  access request
- dmem_we  out  1  write strobe
- dmem_addr  out  32  word address: {ALU_out_EXMEM[31:2],2'b00}
- dmem_wdata  out  32  lane-steered store data
- dmem_be  out  4  byte enables
- dmem_rdata  in  32  read data, valid only with ack
- dmem_ack  in  1  access complete
- stall_MEM  out  1  hold IF/ID/EX and the EX/MEM register
- ALU_out_MEMWB  out  32  registered ALU result
- mem_data_MEMWB  out  32  registered extended load data
- reg_wr_en_MEMWB  out  1  registered writeback enable
- reg_wr_ctrl_MEMWB  out  2  registered writeback select
- rd_MEMWB  out  5  registered destination register
- pc_4_MEMWB  out  32  registered pc+4
- mem_fault_MEMWB  out  1  one-cycle fault flag

Behaviour:
- Decoding:
  - is_load = reg_wr_en_EXMEM && reg_wr_ctrl_EXMEM==01.
  - is_store = mem_wr_en_EXMEM.
  - access = is_load || is_store.
- Fault conditions (evaluated in IDLE):
  - halfword access with addr[0]=1;
  - word access with addr[1:0]!=0;
  - load funct3 of 011, 110 or 111;
  - store funct3 other than 000, 001 or 010.
  - A faulting access issues no request and does not stall. It registers a bubble: reg_wr_en_MEMWB=0, mem_fault_MEMWB=1 for one cycle.
- Store steering:
  - SB: wdata={4{rs2[7:0]}}, be=4'b0001<<addr[1:0].
  - SH: wdata={2{rs2[15:0]}}, be = addr[1] ? 1100 : 0011.
  - SW: wdata=rs2, be=1111.
  - Loads drive be=1111, we=0.
- Load extraction (from dmem_rdata in the ack cycle):
  - LB/LBU: byte at addr[1:0], sign- or zero-extended.
  - LH/LHU: half at addr[1], sign- or zero-extended.
  - LW: unchanged.
- FSM: states IDLE and WAIT.
  - IDLE, valid access:
    - dmem_req=1 combinationally.
    - If dmem_ack is high in the same cycle, the access completes: zero-wait, no stall, MEM/WB loads at the next edge.
    - Otherwise go to WAIT and assert stall_MEM=1.
  - WAIT:
    - dmem_req=1, stall_MEM=1.
    - addr, wdata, be and we are held stable, because EX/MEM is frozen by the stall.
    - MEM/WB receives a bubble (reg_wr_en_MEMWB=0) each stalled cycle.
    - On dmem_ack: complete, return to IDLE, stall_MEM=0 that cycle, MEM/WB loads the instruction.
  - Timeout: the counter clears on entering WAIT and increments each WAIT cycle. When TIMEOUT_CYCLES!=0 and the count reaches TIMEOUT_CYCLES without ack:
    - abort, return to IDLE, deassert stall;
    - register a bubble with mem_fault_MEMWB=1.
    - An ack arriving in the abort cycle takes priority: the access completes normally.
- Non-memory instructions pass straight through, registering all fields. mem_data_MEMWB holds its previous value.
- dmem_ack is ignored when dmem_req=0.
- Latency: one cycle EX/MEM → MEM/WB with a zero-wait memory; 1+N cycles with N wait states.
- Reset:
  - FSM to IDLE, counter to 0.
  - All MEM/WB outputs to 0, including mem_fault_MEMWB.
  - dmem_req, dmem_we, stall_MEM to 0 once the state is IDLE. With reset asserted, the block issues no new request.
  - A reset arriving in WAIT abandons the access with no fault flagged.

Test Plan:
- LW with addr=0x10 and zero-wait ack, rdata=0xDEADBEEF → no stall; next cycle mem_data_MEMWB=0xDEADBEEF, reg_wr_en_MEMWB=1, rd passed through.
- LB addr=0x13 and LBU addr=0x13, rdata=0x80FF0000 → 0xFFFFFF80 and 0x00000080 respectively; LH addr=0x12 → 0xFFFF80FF.
- SB addr=0x21 with rs2=0x000000AB, ack after 3 cycles → be=0010, wdata=0xABABABAB; stall_MEM=1 for 3 cycles with fields stable; 3 bubbles then writeback fields.
- SW addr=0x22 → no dmem_req, no stall, mem_fault_MEMWB=1 for one cycle, reg_wr_en_MEMWB=0.
- TIMEOUT_CYCLES=4 with load, ack never → stall for 4 cycles, then abort, fault=1 once; the following ALU instruction passes normally.
- Reset asserted in the 2nd WAIT cycle → next cycle dmem_req=0, stall_MEM=0, all MEM/WB outputs 0; a late ack is ignored.

Source files
------------

// File: rtl/mem_stage.sv
// Pipeline MEM stage: data-memory access over a req/ack port with byte-lane
// steering and load extension, stall generation, timeout abort and MEM/WB register.
module mem_stage #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TCNT_W         = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] ALU_out_EXMEM,
   input  logic [2:0]  funct3_EXMEM,
   input  logic        mem_wr_en_EXMEM,
   input  logic [31:0] rs2_data_EXMEM,
   input  logic        reg_wr_en_EXMEM,
   input  logic [1:0]  reg_wr_ctrl_EXMEM,
   input  logic [4:0]  rd_EXMEM,
   input  logic [31:0] pc_4_EXMEM,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic        stall_MEM,
   output logic [31:0] ALU_out_MEMWB,
   output logic [31:0] mem_data_MEMWB,
   output logic        reg_wr_en_MEMWB,
   output logic [1:0]  reg_wr_ctrl_MEMWB,
   output logic [4:0]  rd_MEMWB,
   output logic [31:0] pc_4_MEMWB,
   output logic        mem_fault_MEMWB
);
   // state  | meaning
   // S_IDLE | no access outstanding; a new access is requested combinationally
   // S_WAIT | access issued, waiting for ack; EX/MEM frozen by stall_MEM
   typedef enum logic {S_IDLE, S_WAIT} state_t;

   localparam int TO_LAST_I = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
   localparam logic [TCNT_W-1:0] TO_LAST = TO_LAST_I[TCNT_W-1:0];

   state_t            state;
   logic [TCNT_W-1:0] tcnt;
   logic              is_load, is_store, access, bad_op, acc_fault;
   logic              timeout_hit, complete, abort;
   logic [7:0]        byte_sel;
   logic [15:0]       half_sel;
   logic [31:0]       load_data;

   always_comb begin
      is_load  = reg_wr_en_EXMEM && (reg_wr_ctrl_EXMEM == 2'b01);
      is_store = mem_wr_en_EXMEM;
      access   = is_load || is_store;
      bad_op   = 1'b0;
      if (is_store)
         bad_op = !(funct3_EXMEM inside {3'b000, 3'b001, 3'b010});
      else if (is_load)
         bad_op = funct3_EXMEM inside {3'b011, 3'b110, 3'b111};
      if (funct3_EXMEM[1:0] == 2'b01 && ALU_out_EXMEM[0])
         bad_op = 1'b1;
      if (funct3_EXMEM[1:0] == 2'b10 && ALU_out_EXMEM[1:0] != 2'b00)
         bad_op = 1'b1;
      acc_fault = access && bad_op;
   end

   // Reset gates the request so no new access starts while reset is held.
   always_comb begin
      timeout_hit = (TIMEOUT_CYCLES != 0) && (state == S_WAIT) && (tcnt == TO_LAST);
      dmem_req    = !reset && ((state == S_WAIT) || (access && !acc_fault));
      dmem_we     = dmem_req && is_store;
      complete    = dmem_req && dmem_ack;
      stall_MEM   = dmem_req && !dmem_ack && !timeout_hit;
      abort       = dmem_req && !dmem_ack && timeout_hit;
      dmem_addr   = {ALU_out_EXMEM[31:2], 2'b00};
   end

   always_comb begin
      dmem_wdata = rs2_data_EXMEM;
      dmem_be    = 4'b1111;
      if (is_store) begin
         case (funct3_EXMEM[1:0])
            2'b00: begin
               dmem_wdata = {4{rs2_data_EXMEM[7:0]}};
               dmem_be    = 4'b0001 << ALU_out_EXMEM[1:0];
            end
            2'b01: begin
               dmem_wdata = {2{rs2_data_EXMEM[15:0]}};
               dmem_be    = ALU_out_EXMEM[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      byte_sel = 8'(dmem_rdata >> {ALU_out_EXMEM[1:0], 3'b000});
      half_sel = ALU_out_EXMEM[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (funct3_EXMEM)
         3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
         3'b100:  load_data = {24'h0, byte_sel};
         3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
         3'b101:  load_data = {16'h0, half_sel};
         default: load_data = dmem_rdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state             <= S_IDLE;
         tcnt              <= '0;
         ALU_out_MEMWB     <= '0;
         mem_data_MEMWB    <= '0;
         reg_wr_en_MEMWB   <= 1'b0;
         reg_wr_ctrl_MEMWB <= '0;
         rd_MEMWB          <= '0;
         pc_4_MEMWB        <= '0;
         mem_fault_MEMWB   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (stall_MEM) begin
               state <= S_WAIT;
               tcnt  <= '0;
            end
            S_WAIT: if (complete || abort) state <= S_IDLE;
                    else tcnt <= tcnt + 1'b1;
            default: state <= S_IDLE;
         endcase

         mem_fault_MEMWB <= 1'b0;
         if (complete || (state == S_IDLE && !access)) begin
            ALU_out_MEMWB     <= ALU_out_EXMEM;
            reg_wr_en_MEMWB   <= reg_wr_en_EXMEM;
            reg_wr_ctrl_MEMWB <= reg_wr_ctrl_EXMEM;
            rd_MEMWB          <= rd_EXMEM;
            pc_4_MEMWB        <= pc_4_EXMEM;
            if (complete && is_load)
               mem_data_MEMWB <= load_data;
         end else if (stall_MEM) begin
            reg_wr_en_MEMWB <= 1'b0;
         end else begin
            reg_wr_en_MEMWB <= 1'b0;
            mem_fault_MEMWB <= abort || acc_fault;
         end
      end
   end
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: stimulus pushes expected MEM/WB records,
// a negedge monitor pops and compares them whenever MEM/WB shows a writeback or fault.
module tb_mem_stage;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] ALU_out_EXMEM = '0;
   logic [2:0]  funct3_EXMEM = '0;
   logic        mem_wr_en_EXMEM = 1'b0;
   logic [31:0] rs2_data_EXMEM = '0;
   logic        reg_wr_en_EXMEM = 1'b0;
   logic [1:0]  reg_wr_ctrl_EXMEM = '0;
   logic [4:0]  rd_EXMEM = '0;
   logic [31:0] pc_4_EXMEM = '0;
   logic        dmem_req, dmem_we, dmem_ack = 1'b0, stall_MEM;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = '0;
   logic [3:0]  dmem_be;
   logic [31:0] ALU_out_MEMWB, mem_data_MEMWB, pc_4_MEMWB;
   logic        reg_wr_en_MEMWB, mem_fault_MEMWB;
   logic [1:0]  reg_wr_ctrl_MEMWB;
   logic [4:0]  rd_MEMWB;

   mem_stage #(.TIMEOUT_CYCLES(4), .TCNT_W(8)) dut (
      .clk(clk), .reset(reset),
      .ALU_out_EXMEM(ALU_out_EXMEM), .funct3_EXMEM(funct3_EXMEM),
      .mem_wr_en_EXMEM(mem_wr_en_EXMEM), .rs2_data_EXMEM(rs2_data_EXMEM),
      .reg_wr_en_EXMEM(reg_wr_en_EXMEM), .reg_wr_ctrl_EXMEM(reg_wr_ctrl_EXMEM),
      .rd_EXMEM(rd_EXMEM), .pc_4_EXMEM(pc_4_EXMEM),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
      .dmem_ack(dmem_ack), .stall_MEM(stall_MEM),
      .ALU_out_MEMWB(ALU_out_MEMWB), .mem_data_MEMWB(mem_data_MEMWB),
      .reg_wr_en_MEMWB(reg_wr_en_MEMWB), .reg_wr_ctrl_MEMWB(reg_wr_ctrl_MEMWB),
      .rd_MEMWB(rd_MEMWB), .pc_4_MEMWB(pc_4_MEMWB), .mem_fault_MEMWB(mem_fault_MEMWB)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        fault;
      logic [4:0]  rd;
      logic [1:0]  ctrl;
      logic [31:0] alu;
      logic [31:0] pc;
      logic [31:0] data;
   } wb_t;

   wb_t sb[$];
   wb_t e;
   int  n_cmp = 0;
   int  n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic push_wb(input logic fault, input logic [4:0] rd, input logic [1:0] ctrl,
                          input logic [31:0] alu, input logic [31:0] pc, input logic [31:0] data);
      wb_t w;
      w.fault = fault; w.rd = rd; w.ctrl = ctrl; w.alu = alu; w.pc = pc; w.data = data;
      sb.push_back(w);
   endtask

   always @(negedge clk) begin
      if (!reset && (reg_wr_en_MEMWB || mem_fault_MEMWB)) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wb_unexpected: got wen=%b fault=%b rd=%0d, expected no writeback",
                     reg_wr_en_MEMWB, mem_fault_MEMWB, rd_MEMWB);
         end else begin
            e = sb.pop_front();
            chk("wb_fault", 32'(mem_fault_MEMWB), 32'(e.fault));
            chk("wb_wen", 32'(reg_wr_en_MEMWB), 32'(!e.fault));
            if (!e.fault) begin
               chk("wb_rd", 32'(rd_MEMWB), 32'(e.rd));
               chk("wb_ctrl", 32'(reg_wr_ctrl_MEMWB), 32'(e.ctrl));
               chk("wb_alu", ALU_out_MEMWB, e.alu);
               chk("wb_pc4", pc_4_MEMWB, e.pc);
               chk("wb_data", mem_data_MEMWB, e.data);
            end
         end
      end
   end

   int          n_stall;
   logic        req0, we0, stable;
   logic [3:0]  be0;
   logic [31:0] wd0, addr0;
   logic [31:0] last_load = 32'h0;

   // Presents one EX/MEM instruction and holds it while stall_MEM is high.
   // dmem_ack rises in cycle index 'waits' (0 = same cycle as the request).
   task automatic run_instr(input logic [2:0] f3, input logic [31:0] alu, input logic st,
                            input logic [31:0] rs2, input logic wen, input logic [1:0] ctrl,
                            input logic [4:0] rd, input logic [31:0] pc,
                            input logic [31:0] rdata, input int waits);
      logic done = 1'b0;
      n_stall = 0; stable = 1'b1;
      funct3_EXMEM = f3; ALU_out_EXMEM = alu; mem_wr_en_EXMEM = st; rs2_data_EXMEM = rs2;
      reg_wr_en_EXMEM = wen; reg_wr_ctrl_EXMEM = ctrl; rd_EXMEM = rd; pc_4_EXMEM = pc;
      dmem_rdata = rdata;
      for (int c = 0; c < 60 && !done; c++) begin
         dmem_ack = (c == waits);
         @(negedge clk);
         if (c == 0) begin
            req0 = dmem_req; we0 = dmem_we; be0 = dmem_be; wd0 = dmem_wdata; addr0 = dmem_addr;
         end else if (!dmem_req || dmem_we !== we0 || dmem_be !== be0 ||
                      dmem_wdata !== wd0 || dmem_addr !== addr0) begin
            stable = 1'b0;
         end
         if (stall_MEM) n_stall++;
         else done = 1'b1;
         @(posedge clk); #1;
      end
      if (!done) chk("stall_bound", 32'(n_stall), 32'd60);
      mem_wr_en_EXMEM = 1'b0; reg_wr_en_EXMEM = 1'b0; dmem_ack = 1'b0;
   endtask

   task automatic do_load(input string nm, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] rdata, input int waits, input logic [4:0] rd,
                          input logic [31:0] exp_data);
      push_wb(1'b0, rd, 2'b01, a, a + 32'h100, exp_data);
      run_instr(f3, a, 1'b0, 32'h0, 1'b1, 2'b01, rd, a + 32'h100, rdata, waits);
      last_load = exp_data;
      chk({nm, "_stalls"}, 32'(n_stall), 32'(waits));
      chk({nm, "_req"}, 32'(req0), 32'd1);
      chk({nm, "_we_be"}, {27'h0, we0, be0}, {27'h0, 1'b0, 4'hF});
      chk({nm, "_addr"}, addr0, {a[31:2], 2'b00});
   endtask

   task automatic do_store(input string nm, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] rs2, input int waits,
                           input logic [3:0] exp_be, input logic [31:0] exp_wd);
      run_instr(f3, a, 1'b1, rs2, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, waits);
      chk({nm, "_stalls"}, 32'(n_stall), 32'(waits));
      chk({nm, "_req_we"}, {30'h0, req0, we0}, 32'd3);
      chk({nm, "_be"}, 32'(be0), 32'(exp_be));
      chk({nm, "_wdata"}, wd0, exp_wd);
      if (waits > 0) chk({nm, "_stable"}, 32'(stable), 32'd1);
   endtask

   task automatic do_fault(input string nm, input logic [2:0] f3, input logic [31:0] a,
                           input logic st);
      push_wb(1'b1, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0);
      run_instr(f3, a, st, 32'h5555AAAA, !st, st ? 2'b00 : 2'b01, 5'd9, 32'h0, 32'h0, 0);
      chk({nm, "_req"}, 32'(req0), 32'd0);
      chk({nm, "_stalls"}, 32'(n_stall), 32'd0);
   endtask

   task automatic do_alu(input string nm, input logic [31:0] alu, input logic [1:0] ctrl,
                         input logic [4:0] rd, input logic [31:0] pc);
      push_wb(1'b0, rd, ctrl, alu, pc, last_load);
      run_instr(3'b010, alu, 1'b0, 32'h0, 1'b1, ctrl, rd, pc, 32'hCAFEF00D, 0);
      chk({nm, "_req"}, 32'(req0), 32'd0);
      chk({nm, "_stalls"}, 32'(n_stall), 32'd0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_req_stall", {30'h0, dmem_req, stall_MEM}, 32'd0);
      chk("rst_wb_zero", ALU_out_MEMWB | mem_data_MEMWB | pc_4_MEMWB |
          {24'h0, reg_wr_en_MEMWB, mem_fault_MEMWB, reg_wr_ctrl_MEMWB, 4'h0} | {27'h0, rd_MEMWB},
          32'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      do_load("lw",  3'b010, 32'h10, 32'hDEADBEEF, 0, 5'd5, 32'hDEADBEEF);
      do_load("lb",  3'b000, 32'h13, 32'h80FF0000, 0, 5'd6, 32'hFFFFFF80);
      do_load("lbu", 3'b100, 32'h13, 32'h80FF0000, 1, 5'd7, 32'h00000080);
      do_load("lh",  3'b001, 32'h12, 32'h80FF0000, 0, 5'd8, 32'hFFFF80FF);
      do_load("lhu", 3'b101, 32'h12, 32'h80FF0000, 2, 5'd9, 32'h000080FF);
      do_load("lb0", 3'b000, 32'h20, 32'h1234567F, 0, 5'd1, 32'h0000007F);

      do_store("sb", 3'b000, 32'h21, 32'h000000AB, 3, 4'b0010, 32'hABABABAB);
      do_store("sh", 3'b001, 32'h22, 32'hFFFF1234, 1, 4'b1100, 32'h12341234);
      do_store("sw", 3'b010, 32'h24, 32'h89ABCDEF, 0, 4'b1111, 32'h89ABCDEF);

      do_alu("alu1", 32'h00001234, 2'b00, 5'd10, 32'h00000104);
      do_alu("jal",  32'h00000040, 2'b10, 5'd1,  32'h00000208);

      do_fault("sw_mis", 3'b010, 32'h22, 1'b1);
      do_fault("lh_mis", 3'b001, 32'h13, 1'b0);
      do_fault("ld_f3",  3'b011, 32'h18, 1'b0);
      do_fault("st_f3",  3'b100, 32'h18, 1'b1);

      // Memory never acks: 4 stalled cycles, then abort with a fault bubble.
      push_wb(1'b1, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0);
      run_instr(3'b010, 32'h40, 1'b0, 32'h0, 1'b1, 2'b01, 5'd12, 32'h300, 32'h0, 1000);
      chk("to_stalls", 32'(n_stall), 32'd4);
      chk("to_stable", 32'(stable), 32'd1);
      do_alu("alu_after_to", 32'h00ABCDEF, 2'b00, 5'd13, 32'h00000304);

      // Ack in the abort cycle wins over the timeout.
      do_load("lw_ack_abort", 3'b010, 32'h44, 32'h11223344, 4, 5'd14, 32'h11223344);
      do_alu("alu_after_ack", 32'h00000077, 2'b00, 5'd15, 32'h00000404);

      // Reset during the second WAIT cycle abandons the access without a fault.
      funct3_EXMEM = 3'b010; ALU_out_EXMEM = 32'h50; reg_wr_en_EXMEM = 1'b1;
      reg_wr_ctrl_EXMEM = 2'b01; rd_EXMEM = 5'd16; pc_4_EXMEM = 32'h504; dmem_ack = 1'b0;
      @(negedge clk);
      chk("rw_stall0", 32'(stall_MEM), 32'd1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; reg_wr_en_EXMEM = 1'b0; dmem_ack = 1'b1;
      @(negedge clk);
      chk("rw_req_stall", {30'h0, dmem_req, stall_MEM}, 32'd0);
      chk("rw_wb_zero", ALU_out_MEMWB | mem_data_MEMWB | pc_4_MEMWB |
          {24'h0, reg_wr_en_MEMWB, mem_fault_MEMWB, reg_wr_ctrl_MEMWB, 4'h0} | {27'h0, rd_MEMWB},
          32'd0);
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      last_load = 32'h0;
      do_alu("alu_after_rst", 32'h00000099, 2'b00, 5'd17, 32'h00000604);

      repeat (3) @(posedge clk);
      #1;
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
